// File: rtl/fetch_unit_pkg.sv
// Shared core definitions for the fetch stage:
// word sizes, default reset PC and the fetch FSM state type.
package fetch_unit_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic {
    FS_REQ  = 1'b0,
    FS_WAIT = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_mux.sv
// 2-input XLEN-bit mux: y_o = sel_i ? b_i : a_i.
// Ports: sel_i select, a_i/b_i data inputs, y_o result.
module fetch_unit_mux
  import fetch_unit_pkg::*;
(
  input  logic            sel_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] y_o
);

  assign y_o = sel_i ? b_i : a_i;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding imem request, one-entry output buffer.
// Ports: clk/rst, redirect_*, imem_* request/response, if_* downstream handshake.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [ILEN-1:0] imem_rdata,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [ILEN-1:0] if_instr,
  input  logic            if_ready
);

  localparam logic [XLEN-1:0] ALIGN = ~XLEN'(3);

  fetch_state_e    state_q, state_d;
  logic            drop_q, drop_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            vld_q, vld_d;
  logic [XLEN-1:0] ipc_q, ipc_d;
  logic [ILEN-1:0] instr_q, instr_d;
  logic            adv;
  logic [XLEN-1:0] nxt_pc;

  // Request only with an empty buffer; never during reset.
  assign imem_req  = (state_q == FS_REQ) && !vld_q && !rst;
  assign imem_addr = pc_q & ALIGN;

  fetch_unit_mux u_pc_mux (
    .sel_i (redirect_valid),
    .a_i   (pc_q + XLEN'(4)),
    .b_i   (redirect_pc & ALIGN),
    .y_o   (nxt_pc)
  );

  always_comb begin
    state_d = state_q;
    drop_d  = drop_q;
    vld_d   = vld_q;
    ipc_d   = ipc_q;
    instr_d = instr_q;
    adv     = 1'b0;
    if (vld_q && if_ready) vld_d = 1'b0;
    unique case (state_q)
      FS_REQ: begin
        if (imem_req && imem_gnt) begin
          state_d = FS_WAIT;
          // Redirect with grant: old-pc response is stale.
          drop_d  = redirect_valid;
        end
      end
      FS_WAIT: begin
        if (imem_rvalid) begin
          state_d = FS_REQ;
          drop_d  = 1'b0;
          if (!drop_q && !redirect_valid) begin
            adv     = 1'b1;
            vld_d   = 1'b1;
            ipc_d   = pc_q;
            instr_d = imem_rdata;
          end
        end else if (redirect_valid) begin
          drop_d = 1'b1;
        end
      end
      default: ;
    endcase
    // Flush wins over a same-cycle consume.
    if (redirect_valid) vld_d = 1'b0;
    pc_d = (redirect_valid || adv) ? nxt_pc : pc_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FS_REQ;
      drop_q  <= 1'b0;
      pc_q    <= RESET_PC;
      vld_q   <= 1'b0;
      ipc_q   <= '0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
      pc_q    <= pc_d;
      vld_q   <= vld_d;
      ipc_q   <= ipc_d;
      instr_q <= instr_d;
    end
  end

  assign if_valid = vld_q;
  assign if_pc    = ipc_q;
  assign if_instr = instr_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: table-driven stream plus
// hand sequences for stall, redirect, wrap and reset corners.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req, w_req;
  logic [31:0] imem_addr, w_addr;
  logic        imem_gnt, imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid, w_valid;
  logic [31:0] if_pc, if_instr, w_pc, w_instr;
  logic        if_ready;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
    .if_ready(if_ready)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(w_req), .imem_addr(w_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .if_valid(w_valid), .if_pc(w_pc), .if_instr(w_instr),
    .if_ready(if_ready)
  );

  typedef struct {
    logic        rst, gnt, rv;
    logic [31:0] rd;
    logic        rdy;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pc, ins, waddr;
  } row_t;

  row_t tbl[10];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic g, input logic v,
                      input logic [31:0] d, input logic rdy,
                      input logic rv, input logic [31:0] rp);
    @(negedge clk);
    rst = r; imem_gnt = g; imem_rvalid = v; imem_rdata = d;
    if_ready = rdy; redirect_valid = rv; redirect_pc = rp;
    #1;
  endtask

  task automatic expo(input string nm, input logic req,
                      input logic [31:0] addr, input logic vld,
                      input logic [31:0] pc, input logic [31:0] ins);
    chk({nm, ".req"}, 32'(imem_req), 32'(req));
    chk({nm, ".addr"}, imem_addr, addr);
    chk({nm, ".vld"}, 32'(if_valid), 32'(vld));
    chk({nm, ".pc"}, if_pc, pc);
    chk({nm, ".ins"}, if_instr, ins);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //         rst gnt rv rdata  rdy req addr vld pc  ins  waddr
    tbl[0] = '{1,1,0,32'h0,1, 0,32'h0,0,32'h0,32'h0,32'hFFFF_FFFC};
    tbl[1] = '{0,1,0,32'h0,1, 1,32'h0,0,32'h0,32'h0,32'hFFFF_FFFC};
    tbl[2] = '{0,1,1,32'h13,1,0,32'h0,0,32'h0,32'h0,32'hFFFF_FFFC};
    tbl[3] = '{0,1,0,32'h0,1, 0,32'h4,1,32'h0,32'h13,32'h0};
    tbl[4] = '{0,1,0,32'h0,1, 1,32'h4,0,32'h0,32'h13,32'h0};
    tbl[5] = '{0,1,1,32'h13,1,0,32'h4,0,32'h0,32'h13,32'h0};
    tbl[6] = '{0,1,0,32'h0,1, 0,32'h8,1,32'h4,32'h13,32'h4};
    tbl[7] = '{0,1,0,32'h0,1, 1,32'h8,0,32'h4,32'h13,32'h4};
    tbl[8] = '{0,1,1,32'h13,1,0,32'h8,0,32'h4,32'h13,32'h4};
    tbl[9] = '{0,1,0,32'h0,1, 0,32'hC,1,32'h8,32'h13,32'h8};

    rst = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0;
    imem_rdata = '0; if_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 10; i++) begin
      step(tbl[i].rst, tbl[i].gnt, tbl[i].rv, tbl[i].rd,
           tbl[i].rdy, 1'b0, 32'h0);
      expo($sformatf("row%0d", i), tbl[i].req, tbl[i].addr,
           tbl[i].vld, tbl[i].pc, tbl[i].ins);
      chk($sformatf("row%0d.waddr", i), w_addr, tbl[i].waddr);
    end

    // Back-pressure: buffer held, no new request.
    step(0, 1, 0, 32'h0, 0, 0, 32'h0);
    expo("st_req", 1, 32'hC, 0, 32'h8, 32'h13);
    step(0, 1, 1, 32'hDEADBEEF, 0, 0, 32'h0);
    expo("st_rv", 0, 32'hC, 0, 32'h8, 32'h13);
    for (int k = 0; k < 5; k++) begin
      step(0, 1, 0, 32'h0, 0, 0, 32'h0);
      expo($sformatf("stall%0d", k), 0, 32'h10, 1, 32'hC, 32'hDEADBEEF);
    end
    step(0, 1, 0, 32'h0, 1, 0, 32'h0);
    expo("st_take", 0, 32'h10, 1, 32'hC, 32'hDEADBEEF);
    step(0, 1, 0, 32'h0, 1, 0, 32'h0);
    expo("st_next", 1, 32'h10, 0, 32'hC, 32'hDEADBEEF);

    // Redirects in WAIT (last one wins), stale response dropped.
    step(0, 1, 0, 32'h0, 1, 1, 32'h2000);
    expo("rw_r1", 0, 32'h10, 0, 32'hC, 32'hDEADBEEF);
    step(0, 1, 0, 32'h0, 1, 1, 32'h1002);
    expo("rw_r2", 0, 32'h2000, 0, 32'hC, 32'hDEADBEEF);
    step(0, 1, 1, 32'hBAD0BAD0, 1, 0, 32'h0);
    expo("rw_drop", 0, 32'h1000, 0, 32'hC, 32'hDEADBEEF);
    step(0, 1, 0, 32'h0, 1, 0, 32'h0);
    expo("rw_req", 1, 32'h1000, 0, 32'hC, 32'hDEADBEEF);
    step(0, 1, 1, 32'h11111111, 1, 0, 32'h0);
    expo("rw_rv", 0, 32'h1000, 0, 32'hC, 32'hDEADBEEF);
    step(0, 1, 0, 32'h0, 1, 0, 32'h0);
    expo("rw_out", 0, 32'h1004, 1, 32'h1000, 32'h11111111);

    // Redirect coincident with grant in REQ.
    step(0, 1, 0, 32'h0, 1, 1, 32'h3000);
    expo("rg_gnt", 1, 32'h1004, 0, 32'h1000, 32'h11111111);
    step(0, 1, 1, 32'hBAD0BAD0, 1, 0, 32'h0);
    expo("rg_drop", 0, 32'h3000, 0, 32'h1000, 32'h11111111);
    step(0, 1, 0, 32'h0, 1, 0, 32'h0);
    expo("rg_req", 1, 32'h3000, 0, 32'h1000, 32'h11111111);
    step(0, 1, 1, 32'h22222222, 1, 0, 32'h0);
    expo("rg_rv", 0, 32'h3000, 0, 32'h1000, 32'h11111111);

    // Redirect flushes a held instruction; target gets aligned.
    step(0, 1, 0, 32'h0, 0, 1, 32'h4003);
    expo("fl_hold", 0, 32'h3004, 1, 32'h3000, 32'h22222222);
    step(0, 1, 0, 32'h0, 0, 0, 32'h0);
    expo("fl_req", 1, 32'h4000, 0, 32'h3000, 32'h22222222);

    // Reset in WAIT; late response ignored.
    step(1, 0, 0, 32'h0, 1, 0, 32'h0);
    expo("rs_rst", 0, 32'h4000, 0, 32'h3000, 32'h22222222);
    step(0, 0, 1, 32'hCAFEBABE, 1, 0, 32'h0);
    expo("rs_late", 1, 32'h0, 0, 32'h0, 32'h0);
    step(0, 0, 0, 32'h0, 1, 0, 32'h0);
    expo("rs_idle", 1, 32'h0, 0, 32'h0, 32'h0);
    step(0, 1, 0, 32'h0, 1, 0, 32'h0);
    expo("rs_gnt", 1, 32'h0, 0, 32'h0, 32'h0);
    step(0, 1, 1, 32'h33, 1, 0, 32'h0);
    expo("rs_rv", 0, 32'h0, 0, 32'h0, 32'h0);
    step(0, 1, 0, 32'h0, 1, 0, 32'h0);
    expo("rs_out", 0, 32'h4, 1, 32'h0, 32'h33);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
